ooo_rob_mp: RTL and testbench

Parametrised re-order buffer for the OoO engine. It allocates one entry per cycle from Decode/Rename and accepts up to NUM_RESULT functional-unit/CDB writebacks per cycle. It retires in order to the architectural register file, provides NUM_READ tag-lookup ports for rename-time operand capture, and performs precise-exception and external flushes.

---
 rtl/ooo_rob_mp_pkg.sv | 16 +
 rtl/ooo_rob_wb_select.sv | 27 ++
 rtl/ooo_rob_mp.sv | 182 ++++++++++++++++++
 tb/tb_ooo_rob_mp.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_rob_mp_pkg.sv
// Shared constants for the re-order buffer slice.
// Default port counts and exception cause width.
package ooo_rob_mp_pkg;

  localparam int DEFAULT_NUM_RESULT = 2;
  localparam int DEFAULT_NUM_READ   = 2;
  localparam int EXC_CAUSE_W        = 32;

  typedef struct packed {
    logic                   busy;
    logic                   done;
    logic                   exc_valid;
    logic [EXC_CAUSE_W-1:0] exc_cause;
  } rob_flags_t;

endpackage

// File: rtl/ooo_rob_wb_select.sv
// Lowest-index match of one tag against all result ports.
// Shared by entry writeback and read-port forwarding.
module ooo_rob_wb_select #(
  parameter int NUM_RESULT = 2,
  parameter int TAG_W      = 3,
  parameter int IDX_W      = (NUM_RESULT > 1) ? $clog2(NUM_RESULT) : 1
) (
  input  logic [NUM_RESULT-1:0]       valid_i,
  input  logic [NUM_RESULT*TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0]            match_i,
  output logic                        hit_o,
  output logic [IDX_W-1:0]            idx_o
);

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    // Walk downwards so the lowest matching port is the last to assign.
    for (int p = NUM_RESULT - 1; p >= 0; p--) begin
      if (valid_i[p] && tag_i[p*TAG_W +: TAG_W] == match_i) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/ooo_rob_mp.sv
// Re-order buffer: in-order alloc/retire, multi-port writeback,
// rename-time operand lookup, exception and external flush.
module ooo_rob_mp
  import ooo_rob_mp_pkg::*;
#(
  parameter int ROB_SIZE       = 8,
  parameter int NUM_RESULT     = DEFAULT_NUM_RESULT,
  parameter int NUM_READ       = DEFAULT_NUM_READ,
  parameter int DATA_WIDTH     = 32,
  parameter int PC_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  localparam int TAG_W         = $clog2(ROB_SIZE),
  localparam int CNT_W         = $clog2(ROB_SIZE + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic                             dispatch_valid_i,
  output logic                             dispatch_ready_o,
  input  logic [PC_WIDTH-1:0]              dispatch_pc_i,
  input  logic [REG_ADDR_WIDTH-1:0]        dispatch_rd_addr_i,
  input  logic                             dispatch_rd_write_en_i,
  output logic [TAG_W-1:0]                 dispatch_tag_o,
  input  logic [NUM_RESULT-1:0]            result_valid_i,
  input  logic [NUM_RESULT*TAG_W-1:0]      result_tag_i,
  input  logic [NUM_RESULT*DATA_WIDTH-1:0] result_data_i,
  input  logic [NUM_RESULT-1:0]            result_exc_valid_i,
  input  logic [NUM_RESULT*EXC_CAUSE_W-1:0] result_exc_cause_i,
  input  logic [NUM_READ*TAG_W-1:0]        read_tag_i,
  output logic [NUM_READ-1:0]              read_ready_o,
  output logic [NUM_READ*DATA_WIDTH-1:0]   read_data_o,
  output logic                             commit_valid_o,
  input  logic                             commit_ready_i,
  output logic [PC_WIDTH-1:0]              commit_pc_o,
  output logic [REG_ADDR_WIDTH-1:0]        commit_rd_addr_o,
  output logic                             commit_rd_write_en_o,
  output logic [DATA_WIDTH-1:0]            commit_result_o,
  output logic                             commit_exc_valid_o,
  output logic [EXC_CAUSE_W-1:0]           commit_exc_cause_o,
  output logic                             flush_o,
  output logic [CNT_W-1:0]                 count_o
);

  localparam int IDX_W = (NUM_RESULT > 1) ? $clog2(NUM_RESULT) : 1;

  typedef struct packed {
    logic                      busy;
    logic                      done;
    logic [PC_WIDTH-1:0]       pc;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      rd_we;
    logic [DATA_WIDTH-1:0]     data;
    logic                      exc_valid;
    logic [EXC_CAUSE_W-1:0]    exc_cause;
  } rob_entry_t;

  rob_entry_t       ent_q [ROB_SIZE];
  rob_entry_t       head_e;
  logic [TAG_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] cnt_q;
  logic             flush_q;
  logic             disp_fire, cmt_fire, exc_fire;

  logic [ROB_SIZE-1:0] wb_hit;
  logic [IDX_W-1:0]    wb_idx [ROB_SIZE];

  for (genvar e = 0; e < ROB_SIZE; e++) begin : g_wb
    ooo_rob_wb_select #(
      .NUM_RESULT(NUM_RESULT),
      .TAG_W     (TAG_W),
      .IDX_W     (IDX_W)
    ) u_sel (
      .valid_i(result_valid_i),
      .tag_i  (result_tag_i),
      .match_i(TAG_W'(e)),
      .hit_o  (wb_hit[e]),
      .idx_o  (wb_idx[e])
    );
  end

  for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
    logic [TAG_W-1:0]      rtag;
    logic                  hit, rdy;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] dat;

    assign rtag = read_tag_i[r*TAG_W +: TAG_W];

    ooo_rob_wb_select #(
      .NUM_RESULT(NUM_RESULT),
      .TAG_W     (TAG_W),
      .IDX_W     (IDX_W)
    ) u_sel (
      .valid_i(result_valid_i),
      .tag_i  (result_tag_i),
      .match_i(rtag),
      .hit_o  (hit),
      .idx_o  (idx)
    );

    always_comb begin
      rdy = 1'b0;
      dat = '0;
      if (hit && ent_q[rtag].busy) begin
        rdy = 1'b1;
        dat = result_data_i[idx*DATA_WIDTH +: DATA_WIDTH];
      end else if (ent_q[rtag].done) begin
        rdy = 1'b1;
        dat = ent_q[rtag].data;
      end
    end

    assign read_ready_o[r] = rdy;
    assign read_data_o[r*DATA_WIDTH +: DATA_WIDTH] = dat;
  end

  assign head_e               = ent_q[head_q];
  assign commit_valid_o       = head_e.busy && head_e.done;
  assign commit_pc_o          = head_e.pc;
  assign commit_rd_addr_o     = head_e.rd_addr;
  assign commit_rd_write_en_o = head_e.rd_we;
  assign commit_result_o      = head_e.data;
  assign commit_exc_valid_o   = head_e.exc_valid;
  assign commit_exc_cause_o   = head_e.exc_cause;

  assign dispatch_ready_o = (cnt_q < CNT_W'(ROB_SIZE)) &&
                            !(commit_valid_o && commit_exc_valid_o);
  assign dispatch_tag_o   = tail_q;
  assign count_o          = cnt_q;
  assign flush_o          = flush_q;

  assign disp_fire = dispatch_valid_i && dispatch_ready_o;
  assign cmt_fire  = commit_valid_o && commit_ready_i;
  assign exc_fire  = cmt_fire && commit_exc_valid_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < ROB_SIZE; e++) ent_q[e] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else if (flush_i || exc_fire) begin
      for (int e = 0; e < ROB_SIZE; e++) ent_q[e] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      flush_q <= !flush_i;
    end else begin
      flush_q <= 1'b0;
      // First result wins; later ones leave a completed entry stable.
      for (int e = 0; e < ROB_SIZE; e++) begin
        if (wb_hit[e] && ent_q[e].busy && !ent_q[e].done) begin
          ent_q[e].done      <= 1'b1;
          ent_q[e].data      <=
            result_data_i[wb_idx[e]*DATA_WIDTH +: DATA_WIDTH];
          ent_q[e].exc_valid <= result_exc_valid_i[wb_idx[e]];
          ent_q[e].exc_cause <=
            result_exc_cause_i[wb_idx[e]*EXC_CAUSE_W +: EXC_CAUSE_W];
        end
      end
      if (cmt_fire) begin
        ent_q[head_q] <= '0;
        head_q        <= head_q + 1'b1;
      end
      if (disp_fire) begin
        ent_q[tail_q].busy      <= 1'b1;
        ent_q[tail_q].done      <= 1'b0;
        ent_q[tail_q].pc        <= dispatch_pc_i;
        ent_q[tail_q].rd_addr   <= dispatch_rd_addr_i;
        ent_q[tail_q].rd_we     <= dispatch_rd_write_en_i;
        ent_q[tail_q].data      <= '0;
        ent_q[tail_q].exc_valid <= 1'b0;
        ent_q[tail_q].exc_cause <= '0;
        tail_q                  <= tail_q + 1'b1;
      end
      if (disp_fire && !cmt_fire) cnt_q <= cnt_q + 1'b1;
      else if (cmt_fire && !disp_fire) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_ooo_rob_mp.sv
// Directed bench for ooo_rob_mp with an in-order commit scoreboard.
// Expected commits are queued at dispatch and checked at retirement.
module tb_ooo_rob_mp;

  localparam int RS = 8;
  localparam int NR = 2;
  localparam int NP = 2;
  localparam int DW = 32;
  localparam int TW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush_i = 1'b0;
  logic           dvalid = 1'b0;
  logic           dready;
  logic [31:0]    dpc = '0;
  logic [4:0]     drd = '0;
  logic           dwe = 1'b0;
  logic [TW-1:0]  dtag;
  logic [NR-1:0]  rvalid = '0;
  logic [NR*TW-1:0] rtag = '0;
  logic [NR*DW-1:0] rdata = '0;
  logic [NR-1:0]  rexc = '0;
  logic [NR*32-1:0] rcause = '0;
  logic [NP*TW-1:0] ltag = '0;
  logic [NP-1:0]  lready;
  logic [NP*DW-1:0] ldata;
  logic           cvalid;
  logic           cready = 1'b0;
  logic [31:0]    cpc;
  logic [4:0]     crd;
  logic           cwe;
  logic [DW-1:0]  cres;
  logic           cexc;
  logic [31:0]    ccause;
  logic           flush_o;
  logic [3:0]     count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_pc [RS];
  logic [4:0]  m_rd [RS];
  logic        m_we [RS];
  logic [31:0] m_data [RS];
  logic        m_exc [RS];
  logic [31:0] m_cause [RS];
  logic        m_done [RS];
  int          m_tail = 0;
  int          ord_q [$];

  always #5 clk = ~clk;

  ooo_rob_mp dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .flush_i               (flush_i),
    .dispatch_valid_i      (dvalid),
    .dispatch_ready_o      (dready),
    .dispatch_pc_i         (dpc),
    .dispatch_rd_addr_i    (drd),
    .dispatch_rd_write_en_i(dwe),
    .dispatch_tag_o        (dtag),
    .result_valid_i        (rvalid),
    .result_tag_i          (rtag),
    .result_data_i         (rdata),
    .result_exc_valid_i    (rexc),
    .result_exc_cause_i    (rcause),
    .read_tag_i            (ltag),
    .read_ready_o          (lready),
    .read_data_o           (ldata),
    .commit_valid_o        (cvalid),
    .commit_ready_i        (cready),
    .commit_pc_o           (cpc),
    .commit_rd_addr_o      (crd),
    .commit_rd_write_en_o  (cwe),
    .commit_result_o       (cres),
    .commit_exc_valid_o    (cexc),
    .commit_exc_cause_o    (ccause),
    .flush_o               (flush_o),
    .count_o               (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    ord_q.delete();
    m_tail = 0;
    for (int i = 0; i < RS; i++) m_done[i] = 1'b0;
  endtask

  // One clock: update the model from the settled inputs/outputs, then
  // advance to the next falling edge.
  task automatic cyc();
    int t;
    #1;
    if (flush_i) begin
      model_clear();
    end else begin
      if (cvalid && cready) begin
        if (ord_q.size() == 0) begin
          chk("commit_unexpected", 64'd1, 64'd0);
        end else begin
          t = ord_q.pop_front();
          chk("commit_pc", cpc, m_pc[t]);
          chk("commit_rd", crd, m_rd[t]);
          chk("commit_we", cwe, m_we[t]);
          chk("commit_data", cres, m_data[t]);
          chk("commit_exc", cexc, m_exc[t]);
          chk("commit_cause", ccause, m_cause[t]);
          if (cexc) model_clear();
        end
      end
      for (int p = 0; p < NR; p++) begin
        t = int'(rtag[p*TW +: TW]);
        if (rvalid[p] && !m_done[t]) begin
          m_done[t]  = 1'b1;
          m_data[t]  = rdata[p*DW +: DW];
          m_exc[t]   = rexc[p];
          m_cause[t] = rcause[p*32 +: 32];
        end
      end
      if (dvalid && dready) begin
        chk("dispatch_tag", dtag, m_tail);
        m_pc[m_tail]    = dpc;
        m_rd[m_tail]    = drd;
        m_we[m_tail]    = dwe;
        m_done[m_tail]  = 1'b0;
        m_data[m_tail]  = '0;
        m_exc[m_tail]   = 1'b0;
        m_cause[m_tail] = '0;
        ord_q.push_back(m_tail);
        m_tail = (m_tail + 1) % RS;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic dispatch(input logic [31:0] pc, input logic [4:0] rd);
    dvalid = 1'b1;
    dpc    = pc;
    drd    = rd;
    dwe    = (rd != 0);
    cyc();
    dvalid = 1'b0;
  endtask

  task automatic set_wb(input int p, input int tag, input logic [31:0] d,
                        input logic exc, input logic [31:0] cause);
    rvalid[p]            = 1'b1;
    rtag[p*TW +: TW]     = TW'(tag);
    rdata[p*DW +: DW]    = d;
    rexc[p]              = exc;
    rcause[p*32 +: 32]   = cause;
  endtask

  task automatic wb_clear();
    rvalid = '0;
    rexc   = '0;
  endtask

  task automatic drain();
    int guard = 0;
    cready = 1'b1;
    while (ord_q.size() > 0 && guard < 40) begin
      cyc();
      guard++;
    end
    chk("drain_pending", 64'(ord_q.size()), 64'd0);
    chk("drain_count", count, 4'd0);
    cready = 1'b0;
  endtask

  initial begin
    model_clear();
    #2;
    chk("rst_ready", dready, 1'b1);
    chk("rst_tag", dtag, 3'd0);
    chk("rst_count", count, 4'd0);
    chk("rst_cvalid", cvalid, 1'b0);
    chk("rst_flush", flush_o, 1'b0);
    chk("rst_cpc", cpc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill then retire in order.
    for (int i = 0; i < RS; i++) dispatch(32'h1000 + 32'(4 * i), 5'(i + 1));
    chk("fill_count", count, 4'd8);
    chk("fill_ready", dready, 1'b0);
    cready = 1'b1;
    for (int i = 0; i < RS; i += 2) begin
      set_wb(0, i, 32'hA000 + 32'(i), 1'b0, 0);
      set_wb(1, i + 1, 32'hA001 + 32'(i), 1'b0, 0);
      cyc();
      wb_clear();
    end
    drain();

    // Out-of-order completion, in-order retirement.
    dispatch(32'h100, 5'd3);
    dispatch(32'h104, 5'd4);
    dispatch(32'h108, 5'd5);
    set_wb(0, 2, 32'h33, 1'b0, 0); cyc(); wb_clear();
    chk("ooo_no_commit", cvalid, 1'b0);
    set_wb(1, 0, 32'h11, 1'b0, 0); cyc(); wb_clear();
    set_wb(0, 1, 32'h22, 1'b0, 0); cyc(); wb_clear();
    chk("hold_valid", cvalid, 1'b1);
    chk("hold_pc0", cpc, 32'h100);
    cyc();
    chk("hold_pc1", cpc, 32'h100);
    chk("hold_data", cres, 32'h11);
    drain();

    // Two ports on one tag: port 0 wins, forwarded same cycle.
    for (int i = 0; i < 4; i++) dispatch(32'h180 + 32'(4 * i), 5'd7);
    set_wb(0, 3, 32'hAA, 1'b0, 0);
    set_wb(1, 3, 32'hBB, 1'b0, 0);
    ltag = {3'd4, 3'd3};
    #1;
    chk("fwd_ready", lready, 2'b01);
    chk("fwd_data0", ldata[DW-1:0], 32'hAA);
    chk("fwd_data1", ldata[2*DW-1:DW], 32'h0);
    cyc();
    wb_clear();
    #1;
    chk("rd_ready", lready, 2'b01);
    chk("rd_data0", ldata[DW-1:0], 32'hAA);
    set_wb(0, 4, 32'h44, 1'b0, 0);
    set_wb(1, 5, 32'h55, 1'b0, 0);
    cyc(); wb_clear();
    set_wb(0, 6, 32'h66, 1'b0, 0);
    cyc(); wb_clear();
    drain();

    // Empty flush resets the pointers.
    flush_i = 1'b1; cyc(); flush_i = 1'b0;
    chk("flush_tag", dtag, 3'd0);
    chk("flush_noflush_o", flush_o, 1'b0);

    // Precise exception on tag 1.
    for (int i = 0; i < 4; i++) dispatch(32'h200 + 32'(4 * i), 5'd9);
    set_wb(0, 0, 32'h5, 1'b0, 0);
    set_wb(1, 1, 32'h6, 1'b1, 32'd2);
    cyc(); wb_clear();
    set_wb(0, 2, 32'h7, 1'b0, 0);
    set_wb(1, 3, 32'h8, 1'b0, 0);
    cyc(); wb_clear();
    cready = 1'b1;
    chk("exc_head0", cexc, 1'b0);
    cyc();
    chk("exc_valid", cexc, 1'b1);
    chk("exc_cause", ccause, 32'd2);
    chk("exc_dready", dready, 1'b0);
    cyc();
    chk("exc_flush_o", flush_o, 1'b1);
    chk("exc_count", count, 4'd0);
    chk("exc_cvalid", cvalid, 1'b0);
    cyc();
    chk("exc_flush_pulse", flush_o, 1'b0);
    chk("exc_no_more", cvalid, 1'b0);
    cready = 1'b0;

    // Wrap with head at 5, simultaneous commit/dispatch, then flush.
    for (int i = 0; i < RS; i++) dispatch(32'h300 + 32'(4 * i), 5'd10);
    set_wb(0, 0, 32'h30, 1'b0, 0); set_wb(1, 1, 32'h31, 1'b0, 0);
    cyc(); wb_clear();
    set_wb(0, 2, 32'h32, 1'b0, 0); set_wb(1, 3, 32'h33, 1'b0, 0);
    cyc(); wb_clear();
    set_wb(0, 4, 32'h34, 1'b0, 0);
    cyc(); wb_clear();
    cready = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    cready = 1'b0;
    chk("wrap_count3", count, 4'd3);
    for (int i = 0; i < 5; i++) dispatch(32'h380 + 32'(4 * i), 5'd11);
    chk("wrap_count8", count, 4'd8);
    chk("wrap_full", dready, 1'b0);
    set_wb(0, 5, 32'h35, 1'b0, 0); set_wb(1, 6, 32'h36, 1'b0, 0);
    cyc(); wb_clear();
    set_wb(0, 7, 32'h37, 1'b0, 0); set_wb(1, 0, 32'h38, 1'b0, 0);
    cyc(); wb_clear();
    dvalid = 1'b1; dpc = 32'h400; drd = 5'd12; dwe = 1'b1;
    cready = 1'b1;
    #1;
    chk("full_stall", dready, 1'b0);
    chk("full_tag", dtag, 3'd5);
    cyc();
    chk("full_after", count, 4'd7);
    chk("both_ready", dready, 1'b1);
    chk("both_tag", dtag, 3'd5);
    cyc();
    chk("both_count", count, 4'd7);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0; dvalid = 1'b0; cready = 1'b0;
    chk("xflush_count", count, 4'd0);
    chk("xflush_cvalid", cvalid, 1'b0);
    chk("xflush_flush_o", flush_o, 1'b0);
    chk("xflush_tag", dtag, 3'd0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) dispatch(32'h500 + 32'(4 * i), 5'd13);
    set_wb(0, 0, 32'h50, 1'b0, 0); cyc(); wb_clear();
    chk("pre_rst_cvalid", cvalid, 1'b1);
    chk("pre_rst_count", count, 4'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 4'd0);
    chk("arst_ready", dready, 1'b1);
    chk("arst_tag", dtag, 3'd0);
    chk("arst_cvalid", cvalid, 1'b0);
    chk("arst_cpc", cpc, 32'd0);
    chk("arst_cres", cres, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    dispatch(32'h600, 5'd14);
    set_wb(1, 0, 32'h60, 1'b0, 0); cyc(); wb_clear();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
